alu_reg_sequencer: RTL and testbench

//  Multi-cycle controller that sequences the ALU_REG datapath for one command at a time.
//  For each accepted command it:
//   - reads two source registers from the register file;
//   - drives the combinational ALU (NAND/AND/OR/XOR... slices) with the operands and the opcode;
//   - captures the ALU result and writes it back to the destination register.

---
 rtl/alu_reg_pkg.sv | 20 ++
 rtl/alu_reg_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_reg_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_reg_pkg.sv
// rtl/alu_reg_pkg.sv - state encoding and opcode constants for the ALU_REG sequencer
package alu_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;
  localparam logic [2:0] OP_ADD  = 3'd6;
  localparam logic [2:0] OP_SUB  = 3'd7;

endpackage

// File: rtl/alu_reg_sequencer.sv
// rtl/alu_reg_sequencer.sv - four-state read/exec/write sequencer for the ALU_REG datapath
// Optional STATUS_FLAGS_EN adds zero_flag/par_flag captured from the written result.
module alu_reg_sequencer
  import alu_reg_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [ADDR_W-1:0] cmd_rs3,
  output logic [ADDR_W-1:0] rf_raddr_a,
  output logic [ADDR_W-1:0] rf_raddr_b,
  input  logic [WIDTH-1:0]  rf_rdata_a,
  input  logic [WIDTH-1:0]  rf_rdata_b,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [WIDTH-1:0]  rf_wdata,
  output logic [2:0]        alu_op,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic [WIDTH-1:0]  alu_result,
`ifdef STATUS_FLAGS_EN
  output logic              zero_flag,
  output logic              par_flag,
`endif
  output logic              done,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [ADDR_W-1:0]   rs2_q, rs2_d;
  logic [ADDR_W-1:0]   rs3_q, rs3_d;
  logic [WIDTH-1:0]    opa_q, opa_d;
  logic [WIDTH-1:0]    opb_q, opb_d;
  logic [WIDTH-1:0]    res_q, res_d;
`ifdef STATUS_FLAGS_EN
  logic                zero_q, zero_d;
  logic                par_q, par_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs2_d     = rs2_q;
    rs3_d     = rs3_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
`ifdef STATUS_FLAGS_EN
    zero_d    = zero_q;
    par_d     = par_q;
`endif
    cmd_ready = 1'b0;
    busy      = 1'b1;
    rf_we     = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          op_d    = cmd_op;
          rd_d    = cmd_rd;
          rs2_d   = cmd_rs2;
          rs3_d   = cmd_rs3;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        opa_d   = rf_rdata_a;
        opb_d   = rf_rdata_b;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        res_d   = alu_result;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        rf_we   = 1'b1;
        done    = 1'b1;
`ifdef STATUS_FLAGS_EN
        zero_d  = (res_q == '0);
        par_d   = ^res_q;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset clears every latch so an aborted command leaves nothing behind on the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= '0;
      rd_q   <= '0;
      rs2_q  <= '0;
      rs3_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      res_q  <= '0;
`ifdef STATUS_FLAGS_EN
      zero_q <= 1'b0;
      par_q  <= 1'b0;
`endif
    end else begin
      op_q   <= op_d;
      rd_q   <= rd_d;
      rs2_q  <= rs2_d;
      rs3_q  <= rs3_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      res_q  <= res_d;
`ifdef STATUS_FLAGS_EN
      zero_q <= zero_d;
      par_q  <= par_d;
`endif
    end
  end

  assign rf_raddr_a = rs2_q;
  assign rf_raddr_b = rs3_q;
  assign rf_waddr   = rd_q;
  assign rf_wdata   = res_q;
  assign alu_op     = op_q;
  assign alu_a      = opa_q;
  assign alu_b      = opb_q;
`ifdef STATUS_FLAGS_EN
  assign zero_flag  = zero_q;
  assign par_flag   = par_q;
`endif

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// tb/tb_alu_reg_sequencer.sv - directed bench with register-file and ALU models around the sequencer
module tb_alu_reg_sequencer;
  import alu_reg_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_rd, cmd_rs2, cmd_rs3;
  logic [2:0] rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [7:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic       rf_we;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       done, busy;
`ifdef STATUS_FLAGS_EN
  logic       zero_flag, par_flag;
`endif

  logic       ld_we;
  logic [2:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] rf [8];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_reg_sequencer #(.WIDTH(8), .ADDR_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rs2    (cmd_rs2),
    .cmd_rs3    (cmd_rs3),
    .rf_raddr_a (rf_raddr_a),
    .rf_raddr_b (rf_raddr_b),
    .rf_rdata_a (rf_rdata_a),
    .rf_rdata_b (rf_rdata_b),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
`ifdef STATUS_FLAGS_EN
    .zero_flag  (zero_flag),
    .par_flag   (par_flag),
`endif
    .done       (done),
    .busy       (busy)
  );

  always @(posedge clk) begin
    if (ld_we) rf[ld_addr] <= ld_data;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_NAND: alu_result = ~(alu_a & alu_b);
      OP_NOR:  alu_result = ~(alu_a | alu_b);
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_NOT:  alu_result = ~alu_a;
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_we   = 1'b0;
  endtask

  // Entered and left at a negedge with the DUT in IDLE.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs2,
                         input logic [2:0] rs3, input logic [7:0] ea, input logic [7:0] eb,
                         input logic [7:0] er, input logic ez, input logic ep, input bit noise);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs2   = rs2;
    cmd_rs3   = rs3;
    check("idle_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (noise) begin
      cmd_op = ~op; cmd_rd = ~rd; cmd_rs2 = ~rs2; cmd_rs3 = ~rs3;
    end
    check("read_busy", busy, 1);
    check("read_ready", cmd_ready, 0);
    check("read_raddr_a", rf_raddr_a, rs2);
    check("read_raddr_b", rf_raddr_b, rs3);
    check("read_we", rf_we, 0);
    @(negedge clk);
    if (noise) cmd_valid = 1'b1;
    check("exec_a", alu_a, ea);
    check("exec_b", alu_b, eb);
    check("exec_op", alu_op, op);
    check("exec_ready", cmd_ready, 0);
    check("exec_done", done, 0);
    @(negedge clk);
    check("wr_we", rf_we, 1);
    check("wr_done", done, 1);
    check("wr_waddr", rf_waddr, rd);
    check("wr_wdata", rf_wdata, er);
    check("wr_ready", cmd_ready, 0);
    check("wr_raddr_a", rf_raddr_a, rs2);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("post_we", rf_we, 0);
    check("post_done", done, 0);
    check("post_ready", cmd_ready, 1);
    check("post_busy", busy, 0);
    check("post_rf", rf[rd], er);
`ifdef STATUS_FLAGS_EN
    check("post_zero", zero_flag, ez);
    check("post_par", par_flag, ep);
`else
    if (ez && ep) $display("note: flags disabled");
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] initv [8];
    initv = '{8'hAA, 8'h00, 8'hF0, 8'h3C, 8'h0F, 8'hFF, 8'h00, 8'h00};
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs2 = '0; cmd_rs3 = '0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) load(3'(i), initv[i]);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_we", rf_we, 0);
    check("rst_done", done, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_raddr_a", rf_raddr_a, 0);
    check("rst_raddr_b", rf_raddr_b, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
`ifdef STATUS_FLAGS_EN
    check("rst_zero", zero_flag, 0);
    check("rst_par", par_flag, 0);
`endif

    run_cmd(OP_NAND, 3'd1, 3'd2, 3'd3, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1'b0, 1'b0);
    run_cmd(OP_AND,  3'd4, 3'd4, 3'd5, 8'h0F, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0);
    run_cmd(OP_OR,   3'd6, 3'd2, 3'd3, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b1);
    run_cmd(OP_XOR,  3'd7, 3'd2, 3'd3, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 1'b1);
    run_cmd(OP_NOR,  3'd6, 3'd1, 3'd6, 8'hCF, 8'hFC, 8'h00, 1'b1, 1'b0, 1'b0);
    run_cmd(OP_XOR,  3'd5, 3'd0, 3'd0, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
`ifdef STATUS_FLAGS_EN
    check("hold_zero", zero_flag, 1);
    check("hold_par", par_flag, 0);
`endif

    // Abort a command in EXEC; R4 must keep 0F.
    cmd_valid = 1'b1; cmd_op = OP_OR; cmd_rd = 3'd4; cmd_rs2 = 3'd2; cmd_rs3 = 3'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("abort_exec_a", alu_a, 8'hF0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("abort_we", rf_we, 0);
      check("abort_done", done, 0);
      check("abort_ready", cmd_ready, 1);
      check("abort_busy", busy, 0);
      @(negedge clk);
    end
    check("abort_alu_a", alu_a, 0);
    check("abort_raddr_a", rf_raddr_a, 0);
    check("abort_rf4", rf[4], 8'h0F);
`ifdef STATUS_FLAGS_EN
    check("abort_zero", zero_flag, 0);
`endif

    run_cmd(OP_ADD, 3'd1, 3'd2, 3'd3, 8'hF0, 8'h3C, 8'h2C, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
